// File: rtl/eq_fir_pkg.sv
// Shared sizes and types for the equalizer-band serial FIR front end.
// Coefficients are signed Q(-2).18 values; this block only stores and routes them.
package eq_fir_pkg;

  localparam int TAPS      = 64;
  localparam int CNT_W     = $clog2(TAPS);
  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int FRAC_BITS = 18;

  typedef logic [CNT_W-1:0]  tap_idx_t;
  typedef logic [DATA_W-1:0] sample_t;
  typedef logic [COEF_W-1:0] coef_t;

  localparam tap_idx_t FIRST_TAP = tap_idx_t'(0);
  localparam tap_idx_t LAST_TAP  = tap_idx_t'(TAPS - 1);

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Sample/coefficient bus between the FIR tap sequencer and its host and MAC.
// The master side feeds samples and coefficient updates; the slave side is the sequencer.
interface fir_tap_sequencer_if;
  import eq_fir_pkg::*;

  logic     clk_enable;
  sample_t  filter_in;
  logic     coef_wr_en;
  tap_idx_t coef_wr_addr;
  coef_t    coef_wr_data;
  logic     coef_commit;

  sample_t  input_mux;
  coef_t    product_mux;
  logic     phase_0;
  logic     phase_63;
  logic     commit_pending;

  modport master (
    output clk_enable, filter_in, coef_wr_en, coef_wr_addr, coef_wr_data, coef_commit,
    input  input_mux, product_mux, phase_0, phase_63, commit_pending
  );

  modport slave (
    input  clk_enable, filter_in, coef_wr_en, coef_wr_addr, coef_wr_data, coef_commit,
    output input_mux, product_mux, phase_0, phase_63, commit_pending
  );

endinterface

// File: rtl/fir_coeff_bank.sv
// Double-buffered coefficient store: the host fills the shadow bank at any time and the
// active bank is swapped in only at the frame boundary, so a frame never mixes sets.
module fir_coeff_bank
  import eq_fir_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_en,
  input  tap_idx_t wr_addr,
  input  coef_t    wr_data,
  input  logic     commit,
  input  logic     copy_slot,
  input  tap_idx_t rd_addr,
  output coef_t    rd_data,
  output logic     pending
);

  coef_t           shadow_reg [TAPS];
  coef_t           active_reg [TAPS];
  logic            pending_reg;
  logic            pending_next;
  logic            copy_now;
  logic [TAPS-1:0] wr_hit;

  // A commit landing on the copy edge itself is honoured immediately.
  assign copy_now = copy_slot & (pending_reg | commit);

  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_wr_decode
      assign wr_hit[gi] = wr_en & (wr_addr == tap_idx_t'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow_reg[k] <= '0;
        active_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        if (wr_hit[k]) begin
          shadow_reg[k] <= wr_data;
        end
        // Right-hand side is the pre-edge shadow, so a same-edge write stays in shadow only.
        if (copy_now) begin
          active_reg[k] <= shadow_reg[k];
        end
      end
    end
  end

  always_comb begin
    pending_next = pending_reg;
    if (copy_now) begin
      pending_next = 1'b0;
    end else if (commit) begin
      pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_reg <= 1'b0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign rd_data = active_reg[rd_addr];
  assign pending = pending_reg;

endmodule

// File: rtl/fir_tap_sequencer.sv
// Serial 64-tap FIR front end: tap counter, frame strobes and sample delay line,
// presenting one delay[k]/coef[k] pair per enabled cycle to the shared MAC.
module fir_tap_sequencer
  import eq_fir_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fir_tap_sequencer_if.slave bus
);

  tap_idx_t count_reg;
  tap_idx_t count_next;
  sample_t  delay_reg [TAPS];
  logic     first_slot;
  logic     last_slot;

  // Unqualified by reset so the sequential logic never uses rst as data.
  assign first_slot = bus.clk_enable & (count_reg == FIRST_TAP);
  assign last_slot  = bus.clk_enable & (count_reg == LAST_TAP);
  assign count_next = count_reg + tap_idx_t'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (bus.clk_enable) begin
      count_reg <= count_next;
    end
  end

  // The line shifts only at the frame boundary, so it is stable across the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) begin
        delay_reg[k] <= '0;
      end
    end else if (last_slot) begin
      delay_reg[0] <= bus.filter_in;
      for (int k = 1; k < TAPS; k++) begin
        delay_reg[k] <= delay_reg[k-1];
      end
    end
  end

  fir_coeff_bank u_coeff_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (bus.coef_wr_en),
    .wr_addr   (bus.coef_wr_addr),
    .wr_data   (bus.coef_wr_data),
    .commit    (bus.coef_commit),
    .copy_slot (last_slot),
    .rd_addr   (count_reg),
    .rd_data   (bus.product_mux),
    .pending   (bus.commit_pending)
  );

  assign bus.input_mux = delay_reg[count_reg];
  assign bus.phase_0   = rst & first_slot;
  assign bus.phase_63  = rst & last_slot;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: frame strobes, impulse through the delay line,
// shadow/commit coefficient swaps, enable stall at the boundary and mid-frame reset.
module tb_fir_tap_sequencer;
  import eq_fir_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   f;
  int   k;

  always #5 clk = ~clk;

  fir_tap_sequencer_if bus ();

  fir_tap_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic write_coef(input int addr, input logic [15:0] data);
    bus.coef_wr_en   = 1'b1;
    bus.coef_wr_addr = tap_idx_t'(addr);
    bus.coef_wr_data = data;
  endtask

  // Expected active coefficient at tap kk during frame ff of the main sequence.
  function automatic logic [15:0] exp_coef(input int ff, input int kk);
    logic [15:0] v;
    v = 16'(kk);
    if (ff == 0) v = 16'h0000;
    else if (kk == 5 && ff == 5) v = 16'h1234;
    else if (kk == 5 && ff == 6) v = 16'h5555;
    else if (kk == 5 && ff >= 7) v = 16'hAAAA;
    return v;
  endfunction

  function automatic logic exp_pending(input int ff, input int kk);
    return ((ff == 0 || ff == 4) && kk >= 11) || (ff == 5 && kk >= 41);
  endfunction

  initial begin
    bus.clk_enable   = 1'b1;
    bus.filter_in    = 16'h7FFF;
    bus.coef_wr_en   = 1'b1;
    bus.coef_wr_addr = '0;
    bus.coef_wr_data = 16'hFFFF;
    bus.coef_commit  = 1'b1;

    // Held in reset with live inputs: everything reads zero, strobes forced low.
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_phase_0", 32'(bus.phase_0), 32'd0);
      check("rst_phase_63", 32'(bus.phase_63), 32'd0);
      check("rst_input_mux", 32'(bus.input_mux), 32'd0);
      check("rst_product_mux", 32'(bus.product_mux), 32'd0);
      check("rst_pending", 32'(bus.commit_pending), 32'd0);
    end
    $display("reset held 3 cycles");

    @(negedge clk);
    rst = 1'b1;

    // Frames 0..8 (up to count 62 of frame 8) with clk_enable always high.
    for (int c = 0; c < 575; c++) begin
      f = c / 64;
      k = c % 64;
      bus.clk_enable  = 1'b1;
      bus.coef_wr_en  = 1'b0;
      bus.coef_commit = 1'b0;
      bus.filter_in   = (c == 63) ? 16'd100 : 16'd0;
      if (f == 0 && k < 63) write_coef(k + 1, 16'(k + 1));
      if (f == 0 && k == 10) bus.coef_commit = 1'b1;
      if (f == 4 && k == 3)  write_coef(5, 16'h1234);
      if (f == 4 && k == 10) bus.coef_commit = 1'b1;
      if (f == 5 && k == 20) write_coef(5, 16'h5555);
      if (f == 5 && k == 40) bus.coef_commit = 1'b1;
      if (f == 5 && k == 63) write_coef(5, 16'hAAAA);
      if (f == 6 && k == 63) bus.coef_commit = 1'b1;
      #1;
      check("phase_0", 32'(bus.phase_0), 32'(k == 0));
      check("phase_63", 32'(bus.phase_63), 32'(k == 63));
      check("input_mux", 32'(bus.input_mux), (f >= 1 && k == f - 1) ? 32'd100 : 32'd0);
      check("product_mux", 32'(bus.product_mux), 32'(exp_coef(f, k)));
      check("commit_pending", 32'(bus.commit_pending), 32'(exp_pending(f, k)));
      if (k == 63) $display("frame %0d complete", f);
      @(negedge clk);
    end

    // Count 63 of frame 8: stall with a commit and a new sample waiting.
    bus.clk_enable  = 1'b0;
    bus.coef_commit = 1'b1;
    bus.filter_in   = 16'd77;
    #1;
    check("hold_phase_63_entry", 32'(bus.phase_63), 32'd0);
    check("hold_phase_0_entry", 32'(bus.phase_0), 32'd0);
    check("hold_product_entry", 32'(bus.product_mux), 32'd63);
    @(negedge clk);
    bus.coef_commit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.coef_wr_en = 1'b0;
      if (i == 2) write_coef(5, 16'h0BEE);
      #1;
      check("hold_phase_63", 32'(bus.phase_63), 32'd0);
      check("hold_pending", 32'(bus.commit_pending), 32'd1);
      check("hold_product", 32'(bus.product_mux), 32'd63);
      check("hold_input", 32'(bus.input_mux), 32'd0);
      @(negedge clk);
    end
    bus.coef_wr_en = 1'b0;
    bus.clk_enable = 1'b1;
    #1;
    check("release_phase_63", 32'(bus.phase_63), 32'd1);
    check("release_pending", 32'(bus.commit_pending), 32'd1);
    $display("enable stall of 11 cycles at count 63 released");
    @(negedge clk);
    bus.filter_in = 16'd0;

    // Frame 9: shifted line and swapped-in coefficient, then reset at count 30.
    for (int kk = 0; kk < 30; kk++) begin
      bus.coef_commit = (kk == 10);
      #1;
      check("f9_phase_0", 32'(bus.phase_0), 32'(kk == 0));
      check("f9_pending", 32'(bus.commit_pending), 32'(kk >= 11));
      check("f9_input_mux", 32'(bus.input_mux),
            (kk == 0) ? 32'd77 : ((kk == 8) ? 32'd100 : 32'd0));
      check("f9_product_mux", 32'(bus.product_mux), (kk == 5) ? 32'h0BEE : 32'(kk));
      @(negedge clk);
    end
    bus.coef_commit = 1'b0;
    #1;
    check("pre_rst_pending", 32'(bus.commit_pending), 32'd1);
    rst = 1'b0;
    #1;
    check("async_rst_pending", 32'(bus.commit_pending), 32'd0);
    check("async_rst_product", 32'(bus.product_mux), 32'd0);
    check("async_rst_input", 32'(bus.input_mux), 32'd0);
    check("async_rst_phase_0", 32'(bus.phase_0), 32'd0);
    $display("reset asserted at count 30 with commit pending");
    repeat (3) @(negedge clk);

    rst = 1'b1;
    bus.clk_enable = 1'b0;
    repeat (2) begin
      #1;
      check("post_rst_idle_phase_0", 32'(bus.phase_0), 32'd0);
      @(negedge clk);
    end
    bus.clk_enable = 1'b1;
    for (int kk = 0; kk < 64; kk++) begin
      #1;
      check("post_rst_phase_0", 32'(bus.phase_0), 32'(kk == 0));
      check("post_rst_phase_63", 32'(bus.phase_63), 32'(kk == 63));
      check("post_rst_product", 32'(bus.product_mux), 32'd0);
      check("post_rst_input", 32'(bus.input_mux), 32'd0);
      check("post_rst_pending", 32'(bus.commit_pending), 32'd0);
      @(negedge clk);
    end
    $display("frame after reset complete");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
